// File: rtl/scratch_pad_atomic.sv
// scratch_pad_atomic: multi-port banked scratchpad. Each bank has a round-robin arbiter
// and a two-stage pipeline (S1 RAM access, S2 registered response plus atomic write-back).
module scratch_pad_atomic #(
    parameter int PORTS      = 8,
    parameter int BANKS      = 8,
    parameter int WIDTH      = 64,
    parameter int BANK_DEPTH = 512,
    parameter int ATOMICS    = 1,
    localparam int ADDR_WIDTH = $clog2(BANKS * BANK_DEPTH),
    localparam int BANK_BITS  = $clog2(BANKS),
    localparam int PORT_BITS  = $clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [0:PORTS-1]            req_valid,
    output logic [0:PORTS-1]            req_ready,
    input  logic [2*PORTS-1:0]          req_op,
    input  logic [ADDR_WIDTH*PORTS-1:0] req_addr,
    input  logic [WIDTH*PORTS-1:0]      req_data,
    output logic [0:PORTS-1]            rsp_valid,
    output logic [WIDTH*PORTS-1:0]      rsp_data
);
    localparam int ROW_BITS = ADDR_WIDTH - BANK_BITS;
    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_FA = 2'b10;

    // Value an atomic writes back: old+arg (carry dropped) for fetch-add, arg for swap
    function automatic logic [WIDTH-1:0] atomic_result(input logic [1:0]       op,
                                                       input logic [WIDTH-1:0] old_val,
                                                       input logic [WIDTH-1:0] arg);
        return (op == OP_FA) ? old_val + arg : arg;
    endfunction

    // Per-port request fields
    logic [1:0]           op_w   [PORTS];
    logic [ROW_BITS-1:0]  row_w  [PORTS];
    logic [BANK_BITS-1:0] bank_w [PORTS];
    logic [WIDTH-1:0]     data_w [PORTS];

    // Arbiter state
    logic [PORT_BITS-1:0] ptr_q [BANKS];
    logic [PORT_BITS-1:0] ptr_d [BANKS];
    logic [BANKS-1:0]     gnt_vld;
    logic [PORT_BITS-1:0] gnt_port [BANKS];
    logic [BANKS-1:0]     busy;

    // S1 pipeline registers
    logic [BANKS-1:0]     s1_vld_q, s1_vld_d;
    logic [PORT_BITS-1:0] s1_port_q [BANKS];
    logic [PORT_BITS-1:0] s1_port_d [BANKS];
    logic [1:0]           s1_op_q   [BANKS];
    logic [1:0]           s1_op_d   [BANKS];
    logic [ROW_BITS-1:0]  s1_row_q  [BANKS];
    logic [ROW_BITS-1:0]  s1_row_d  [BANKS];
    logic [WIDTH-1:0]     s1_data_q [BANKS];
    logic [WIDTH-1:0]     s1_data_d [BANKS];

    // S2 pipeline registers (atomics only)
    logic [BANKS-1:0]     s2_vld_q, s2_vld_d;
    logic [1:0]           s2_op_q  [BANKS];
    logic [1:0]           s2_op_d  [BANKS];
    logic [ROW_BITS-1:0]  s2_row_q [BANKS];
    logic [ROW_BITS-1:0]  s2_row_d [BANKS];
    logic [WIDTH-1:0]     s2_arg_q [BANKS];
    logic [WIDTH-1:0]     s2_arg_d [BANKS];
    logic [WIDTH-1:0]     s2_old_q [BANKS];
    logic [WIDTH-1:0]     s2_old_d [BANKS];

    // Bank RAMs and their single write port
    logic [WIDTH-1:0]     mem_q [BANKS][BANK_DEPTH];
    logic [WIDTH-1:0]     rd_word   [BANKS];
    logic [BANKS-1:0]     mem_we;
    logic [ROW_BITS-1:0]  mem_row   [BANKS];
    logic [WIDTH-1:0]     mem_wdata [BANKS];

    // Response registers
    logic [0:PORTS-1]     rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]     rsp_data_q [PORTS];
    logic [WIDTH-1:0]     rsp_data_d [PORTS];

    // Split the flattened request buses; with atomics disabled ops 10/11 act as reads
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            op_w[p] = req_op[(PORTS-p)*2-1 -: 2];
            if (ATOMICS == 0 && op_w[p][1]) op_w[p] = OP_RD;
            {row_w[p], bank_w[p]} = req_addr[(PORTS-p)*ADDR_WIDTH-1 -: ADDR_WIDTH];
            data_w[p] = req_data[(PORTS-p)*WIDTH-1 -: WIDTH];
        end
    end

    // Grant stage: round-robin from ptr per bank; an atomic sitting in S1 blocks its bank
    always_comb begin
        logic [PORT_BITS-1:0] idx;
        idx = '0;
        for (int b = 0; b < BANKS; b++) begin
            gnt_vld[b]  = 1'b0;
            gnt_port[b] = '0;
            ptr_d[b]    = ptr_q[b];
            busy[b]     = s1_vld_q[b] && s1_op_q[b][1];
            for (int i = 0; i < PORTS; i++) begin
                idx = ptr_q[b] + PORT_BITS'(i);
                if (rst && !busy[b] && !gnt_vld[b] && req_valid[idx] &&
                    bank_w[idx] == BANK_BITS'(b)) begin
                    gnt_vld[b]  = 1'b1;
                    gnt_port[b] = idx;
                end
            end
            if (gnt_vld[b]) ptr_d[b] = gnt_port[b] + PORT_BITS'(1);
            s1_vld_d[b]  = gnt_vld[b];
            s1_port_d[b] = gnt_port[b];
            s1_op_d[b]   = op_w[gnt_port[b]];
            s1_row_d[b]  = row_w[gnt_port[b]];
            s1_data_d[b] = data_w[gnt_port[b]];
        end
    end

    // A port targets one bank per cycle, so it can see at most one grant
    always_comb begin
        req_ready = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (gnt_vld[b]) req_ready[gnt_port[b]] = 1'b1;
        end
    end

    // S1 -> S2: RAM read, atomic capture, and selection of the bank write
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            rd_word[b]   = mem_q[b][s1_row_q[b]];
            s2_vld_d[b]  = s1_vld_q[b] && s1_op_q[b][1];
            s2_op_d[b]   = s1_op_q[b];
            s2_row_d[b]  = s1_row_q[b];
            s2_arg_d[b]  = s1_data_q[b];
            s2_old_d[b]  = rd_word[b];
            mem_we[b]    = 1'b0;
            mem_row[b]   = s1_row_q[b];
            mem_wdata[b] = s1_data_q[b];
            if (rst && s2_vld_q[b]) begin
                mem_we[b]    = 1'b1;
                mem_row[b]   = s2_row_q[b];
                mem_wdata[b] = atomic_result(s2_op_q[b], s2_old_q[b], s2_arg_q[b]);
            end else if (rst && s1_vld_q[b] && s1_op_q[b] == OP_WR) begin
                mem_we[b] = 1'b1;
            end
        end
    end

    // S1 -> response registers: every non-write returns the word read in S1
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            rsp_valid_d[p] = 1'b0;
            rsp_data_d[p]  = rsp_data_q[p];
        end
        for (int b = 0; b < BANKS; b++) begin
            if (s1_vld_q[b] && s1_op_q[b] != OP_WR) begin
                rsp_valid_d[s1_port_q[b]] = 1'b1;
                rsp_data_d[s1_port_q[b]]  = rd_word[b];
            end
        end
    end

    // Pack registered responses onto the output buses
    always_comb begin
        rsp_valid = rsp_valid_q;
        rsp_data  = '0;
        for (int p = 0; p < PORTS; p++) begin
            rsp_data[(PORTS-p)*WIDTH-1 -: WIDTH] = rsp_data_q[p];
        end
    end

    // Control flops and responses take reset; pipeline payload does not
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld_q    <= '0;
            s2_vld_q    <= '0;
            rsp_valid_q <= '0;
            for (int b = 0; b < BANKS; b++) ptr_q[b] <= '0;
            for (int p = 0; p < PORTS; p++) rsp_data_q[p] <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s2_vld_q    <= s2_vld_d;
            rsp_valid_q <= rsp_valid_d;
            ptr_q       <= ptr_d;
            rsp_data_q  <= rsp_data_d;
        end
        s1_port_q <= s1_port_d;
        s1_op_q   <= s1_op_d;
        s1_row_q  <= s1_row_d;
        s1_data_q <= s1_data_d;
        s2_op_q   <= s2_op_d;
        s2_row_q  <= s2_row_d;
        s2_arg_q  <= s2_arg_d;
        s2_old_q  <= s2_old_d;
    end

    // Bank RAM write port: S1 plain write or S2 atomic write-back (never both)
    always_ff @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            if (mem_we[b]) mem_q[b][mem_row[b]] <= mem_wdata[b];
        end
    end
endmodule

// File: tb/tb_scratch_pad_atomic.sv
// tb_scratch_pad_atomic: directed stimulus with a per-port scoreboard of expected responses.
module tb_scratch_pad_atomic;
    localparam int P  = 8;
    localparam int W  = 64;
    localparam int AW = 12;
    localparam logic [1:0] RD = 2'b00, WR = 2'b01, FA = 2'b10, SW = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [0:P-1]    req_valid, req_ready, rsp_valid;
    logic [2*P-1:0]  req_op;
    logic [AW*P-1:0] req_addr;
    logic [W*P-1:0]  req_data, rsp_data;
    logic [1:0]      t_op   [P];
    logic [AW-1:0]   t_addr [P];
    logic [W-1:0]    t_data [P];

    always_comb begin
        req_op   = '0;
        req_addr = '0;
        req_data = '0;
        for (int p = 0; p < P; p++) begin
            req_op[(P-p)*2-1 -: 2]    = t_op[p];
            req_addr[(P-p)*AW-1 -: AW] = t_addr[p];
            req_data[(P-p)*W-1 -: W]   = t_data[p];
        end
    end

    scratch_pad_atomic dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        logic [W-1:0] data;
    } exp_t;
    exp_t sb [P][$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [W-1:0] d);
        t_op[p] = op;
        t_addr[p] = a;
        t_data[p] = d;
        req_valid[p] = 1'b1;
    endtask

    // Called in the grant cycle; the response is due two cycles later
    task automatic expect_rsp(input int p, input logic [W-1:0] d);
        exp_t e;
        e.cyc = cyc + 2;
        e.data = d;
        sb[p].push_back(e);
    endtask

    task automatic tick(input logic [0:P-1] exp_rdy, input string name);
        @(negedge clk);
        chk(name, W'(req_ready), W'(exp_rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) tick('0, "idle_ready");
    endtask

    // Monitor: every response must be due this cycle and carry the expected data
    always @(negedge clk) begin
        bit   due;
        exp_t e;
        for (int p = 0; p < P; p++) begin
            due = (sb[p].size() != 0) && (sb[p][0].cyc == cyc);
            if (due || rsp_valid[p] !== 1'b0) begin
                checks++;
                if (rsp_valid[p] !== 1'b1 || !due) begin
                    errors++;
                    $display("FAIL rsp_port%0d cyc %0d: rsp_valid=%b response_due=%0d",
                             p, cyc, rsp_valid[p], due);
                    if (due) void'(sb[p].pop_front());
                end else begin
                    e = sb[p].pop_front();
                    if (rsp_data[(P-p)*W-1 -: W] !== e.data) begin
                        errors++;
                        $display("FAIL rsp_data_port%0d cyc %0d: got %h expected %h",
                                 p, cyc, rsp_data[(P-p)*W-1 -: W], e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < P; p++) begin
            t_op[p] = RD;
            t_addr[p] = '0;
            t_data[p] = '0;
        end
        req_valid = '1;

        // Reset with every port requesting
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", W'(req_ready), '0);
            chk("rst_rsp_valid", W'(rsp_valid), '0);
        end
        rst = 1'b1;
        req_valid = '0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", W'(rsp_valid), '0);
        end
        @(posedge clk);
        #1;

        // Write then read-after-write on port 0
        set_req(0, WR, 12'd5, 64'hAB);
        tick(8'b1000_0000, "t2_wr_ready");
        set_req(0, RD, 12'd5, '0);
        expect_rsp(0, 64'hAB);
        tick(8'b1000_0000, "t2_rd_ready");
        idle(3);

        // All ports write bank 0 rows, serialized 0..7
        for (int p = 0; p < P; p++) set_req(p, WR, AW'(p * 8), W'(64'h100 + p));
        for (int k = 0; k < P; k++) begin
            tick(8'b1000_0000 >> k, "t3_wr_rr");
            req_valid[k] = 1'b0;
        end
        // All ports read bank 0 continuously: grants rotate 0..7,0
        for (int p = 0; p < P; p++) set_req(p, RD, AW'(p * 8), '0);
        for (int k = 0; k < 9; k++) begin
            expect_rsp(k % P, W'(64'h100 + (k % P)));
            tick(8'b1000_0000 >> (k % P), "t3_rd_rr");
        end
        idle(3);

        // Fetch-add wrap at addr 9; bank 1 busy the next cycle, bank 0 unaffected
        set_req(2, WR, 12'd9, '1);
        tick(8'b0010_0000, "t4_wr_ready");
        set_req(2, FA, 12'd9, 64'd2);
        expect_rsp(2, '1);
        tick(8'b0010_0000, "t4_fa_ready");
        req_valid[2] = 1'b0;
        set_req(3, RD, 12'd9, '0);
        set_req(4, RD, 12'd0, '0);
        expect_rsp(4, 64'h100);
        tick(8'b0000_1000, "t4_busy_ready");
        req_valid[4] = 1'b0;
        expect_rsp(3, 64'h1);
        tick(8'b0001_0000, "t4_wb_read_ready");
        idle(3);

        // Swap at addr 3, then read granted two cycles later sees the swapped value
        set_req(1, WR, 12'd3, 64'd4);
        tick(8'b0100_0000, "t5_wr_ready");
        set_req(1, SW, 12'd3, 64'd7);
        expect_rsp(1, 64'd4);
        tick(8'b0100_0000, "t5_swap_ready");
        req_valid[1] = 1'b0;
        set_req(5, RD, 12'd3, '0);
        tick('0, "t5_busy_ready");
        expect_rsp(5, 64'd7);
        tick(8'b0000_0100, "t5_rd_ready");
        idle(3);

        // Eight ports, eight banks: full parallel grants
        for (int p = 0; p < P; p++) set_req(p, WR, AW'(p), W'(64'h200 + p));
        tick('1, "t6_wr_all_ready");
        for (int p = 0; p < P; p++) begin
            set_req(p, RD, AW'(p), '0);
            expect_rsp(p, W'(64'h200 + p));
        end
        tick('1, "t6_rd_all_ready");
        // Second batch is accepted, then reset in the next cycle drops it
        tick('1, "t6_rd_drop_ready");
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_ready", W'(req_ready), '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("t6_dropped_rsp_valid", W'(rsp_valid), '0);
        chk("t6_rst_rsp_data", rsp_data[W*P-1 -: W], '0);
        @(posedge clk);
        #1;

        // RAM keeps its contents across reset
        set_req(0, RD, 12'd0, '0);
        expect_rsp(0, 64'h200);
        set_req(6, RD, 12'd9, '0);
        expect_rsp(6, 64'h1);
        tick(8'b1000_0010, "post_rst_rd_ready");
        idle(4);

        for (int p = 0; p < P; p++) chk("sb_empty", W'(sb[p].size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
